// File: rtl/fft_bfly_sequencer_if.sv
// Issue and write-back bus between the FFT butterfly sequencer and the
// shared butterfly pipeline / sample memory.
interface fft_bfly_sequencer_if #(
    parameter int unsigned LOG2N = 4
);
    logic             issue_valid;
    logic             issue_ready;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wb_valid;
    logic [LOG2N-1:0] wb_addr_a;
    logic [LOG2N-1:0] wb_addr_b;

    modport master (
        output issue_valid, addr_a, addr_b, tw_idx,
        output wb_valid, wb_addr_a, wb_addr_b,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, addr_a, addr_b, tw_idx,
        input  wb_valid, wb_addr_a, wb_addr_b,
        output issue_ready
    );
endinterface

// File: rtl/fft_bfly_sequencer.sv
// In-place radix-2 DIT FFT sequencer: walks stages and butterflies over one
// shared butterfly pipeline and returns write-back addresses after BFLY_LAT.
module fft_bfly_sequencer #(
    parameter int unsigned LOG2N    = 4,
    parameter int unsigned BFLY_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [LOG2N-1:0]     stage,
    fft_bfly_sequencer_if.master bus
);
    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [LOG2N-1:0] inflight_q, inflight_d;
    logic             accept;

    logic [LOG2N-1:0] span_w, idx_w, bunch_w, a_w, b_w, tw_sh;
    logic [LOG2N:0]   a_sh;

    logic [BFLY_LAT-1:0]            sr_v;
    logic [BFLY_LAT-1:0][LOG2N-1:0] sr_a;
    logic [BFLY_LAT-1:0][LOG2N-1:0] sr_b;

    // Butterfly j of stage s: idx = j mod span, bunch = j / span.
    always_comb begin
        span_w  = LOG2N'(1) << stage_q;
        idx_w   = {1'b0, j_q} & (span_w - LOG2N'(1));
        bunch_w = {1'b0, j_q} >> stage_q;
        a_sh    = {1'b0, stage_q} + 1'b1;
        a_w     = (bunch_w << a_sh) | idx_w;
        b_w     = a_w + span_w;
        tw_sh   = LAST_STAGE - stage_q;
    end

    always_comb begin
        bus.wb_valid  = sr_v[BFLY_LAT-1];
        bus.wb_addr_a = sr_a[BFLY_LAT-1];
        bus.wb_addr_b = sr_b[BFLY_LAT-1];
    end

    always_comb begin
        state_d         = state_q;
        j_d             = j_q;
        stage_d         = stage_q;
        busy            = 1'b0;
        done            = 1'b0;
        bus.issue_valid = 1'b0;
        bus.addr_a      = '0;
        bus.addr_b      = '0;
        bus.tw_idx      = '0;
        accept          = (state_q == S_ISSUE) && bus.issue_ready;

        inflight_d = inflight_q;
        case ({accept, bus.wb_valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            S_ISSUE: begin
                busy            = 1'b1;
                bus.issue_valid = 1'b1;
                bus.addr_a      = a_w;
                bus.addr_b      = b_w;
                bus.tw_idx      = (LOG2N-1)'(idx_w << tw_sh);
                if (accept) begin
                    j_d = j_q + 1'b1;
                    if (j_q == '1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Look at the post-update count so the next stage starts the
                // cycle right after the last write-back of this one.
                if (inflight_d == '0) begin
                    if (stage_q != LAST_STAGE) begin
                        stage_d = stage_q + 1'b1;
                        j_d     = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stage = stage_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            stage_q    <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            stage_q    <= stage_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sr_v <= '0;
            sr_a <= '0;
            sr_b <= '0;
        end else begin
            sr_v[0] <= accept;
            sr_a[0] <= accept ? a_w : '0;
            sr_b[0] <= accept ? b_w : '0;
            for (int unsigned i = 1; i < BFLY_LAT; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_a[i] <= sr_a[i-1];
                sr_b[i] <= sr_b[i-1];
            end
        end
    end
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Scoreboard bench for fft_bfly_sequencer: model-generated butterfly order,
// write-back timing and end-of-FFT timing checked by a negedge monitor.
module tb_fft_bfly_sequencer;
    localparam int LOG2N   = 4;
    localparam int LAT     = 3;
    localparam int N       = 1 << LOG2N;
    localparam int NB      = LOG2N * N / 2;
    localparam int RUN_CYC = 1 + LOG2N * (N / 2 + LAT);

    typedef struct {
        int s;
        int a;
        int b;
        int tw;
        bit last;
    } iss_t;

    typedef struct {
        int a;
        int b;
        int due;
        bit last;
    } wb_t;

    logic       clk = 1'b0;
    logic       rst_;
    logic       start;
    logic       busy;
    logic       done;
    logic [LOG2N-1:0] stage;

    fft_bfly_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_bfly_sequencer #(
        .LOG2N   (LOG2N),
        .BFLY_LAT(LAT)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .start(start),
        .busy (busy),
        .done (done),
        .stage(stage),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   exp_first_issue = 0;
    int   last_wb_cyc = 0;
    int   stalls = 0;
    int   wb_count = 0;
    int   acc_j = 0;
    int   rmode = 0;
    bit   pending = 0;
    bit   done_seen = 0;
    bit   prev_iv = 0;
    bit   last_was_end = 0;
    iss_t exp_issue[$];
    wb_t  exp_wb[$];

    int spot_s [4] = '{1, 2, 3, 0};
    int spot_j [4] = '{1, 5, 7, 3};
    int spot_a [4] = '{1, 9, 7, 6};
    int spot_b [4] = '{3, 13, 15, 7};
    int spot_tw[4] = '{4, 2, 7, 0};

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference order: per stage, bunches of 2*span words, pairs span apart.
    function automatic void push_model();
        for (int s = 0; s < LOG2N; s++) begin
            int span = 1 << s;
            for (int base = 0; base < N; base += 2 * span) begin
                for (int i = 0; i < span; i++) begin
                    iss_t t;
                    t.s    = s;
                    t.a    = base + i;
                    t.b    = base + i + span;
                    t.tw   = i * (N / (2 * span));
                    t.last = (base + 2 * span >= N) && (i == span - 1);
                    exp_issue.push_back(t);
                end
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       bus.issue_ready = 1'b1;
            1:       bus.issue_ready = !(cyc >= start_cyc + 4 && cyc <= start_cyc + 8);
            default: bus.issue_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    always @(negedge clk) begin
        if (!rst_) begin
            prev_iv = 0;
            acc_j   = 0;
        end else begin
            if (bus.issue_valid) begin
                chk("busy_in_issue", busy, 1);
                if (!prev_iv) begin
                    chk("first_issue_cycle", cyc, exp_first_issue);
                    if (rmode == 0 && exp_issue.size() > 0 && exp_issue[0].s == 1)
                        chk("stage1_first_issue", cyc - start_cyc, 12);
                    if (rmode == 0 && exp_issue.size() == NB)
                        chk("stage0_first_issue", cyc - start_cyc, 1);
                end
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", bus.issue_valid, 0);
                end else begin
                    iss_t h;
                    h = exp_issue[0];
                    chk("issue_stage", int'(stage), h.s);
                    chk("addr_a", int'(bus.addr_a), h.a);
                    chk("addr_b", int'(bus.addr_b), h.b);
                    chk("tw_idx", int'(bus.tw_idx), h.tw);
                    for (int k = 0; k < 4; k++) begin
                        if (h.s == spot_s[k] && acc_j == spot_j[k]) begin
                            chk("spot_a", int'(bus.addr_a), spot_a[k]);
                            chk("spot_b", int'(bus.addr_b), spot_b[k]);
                            chk("spot_tw", int'(bus.tw_idx), spot_tw[k]);
                        end
                    end
                    if (bus.issue_ready) begin
                        wb_t w;
                        void'(exp_issue.pop_front());
                        w.a    = h.a;
                        w.b    = h.b;
                        w.due  = cyc + LAT;
                        w.last = h.last;
                        exp_wb.push_back(w);
                        last_was_end = h.last;
                        acc_j = h.last ? 0 : acc_j + 1;
                    end else begin
                        stalls++;
                    end
                end
            end else if (prev_iv) begin
                chk("issue_stop_at_stage_end", int'(last_was_end), 1);
            end
            prev_iv = bus.issue_valid;

            if (bus.wb_valid) begin
                chk("busy_in_wb", busy, 1);
                if (exp_wb.size() == 0) begin
                    chk("unexpected_wb", bus.wb_valid, 0);
                end else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    chk("wb_addr_a", int'(bus.wb_addr_a), w.a);
                    chk("wb_addr_b", int'(bus.wb_addr_b), w.b);
                    chk("wb_cycle", cyc, w.due);
                    wb_count++;
                    if (w.last) begin
                        exp_first_issue = cyc + 1;
                        last_wb_cyc     = cyc;
                    end
                end
            end else if (exp_wb.size() > 0 && exp_wb[0].due <= cyc) begin
                chk("wb_missing", bus.wb_valid, 1);
                void'(exp_wb.pop_front());
            end

            if (done) begin
                if (!pending) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    chk("done_after_last_wb", cyc, last_wb_cyc + 1);
                    chk("done_cycle", cyc - start_cyc, RUN_CYC + stalls);
                    if (rmode == 0) chk("nostall_done_cycle", cyc - start_cyc, 45);
                    if (rmode == 1) chk("stall_done_cycle", cyc - start_cyc, 50);
                    chk("wb_count", wb_count, NB);
                    chk("busy_at_done", busy, 0);
                    chk("issues_left", exp_issue.size(), 0);
                    pending   = 0;
                    done_seen = 1;
                end
            end
        end
    end

    task automatic start_fft();
        @(posedge clk);
        #1;
        start           = 1'b1;
        start_cyc       = cyc;
        exp_first_issue = cyc + 1;
        stalls          = 0;
        wb_count        = 0;
        acc_j           = 0;
        done_seen       = 0;
        pending         = 1;
        push_model();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (done_seen) break;
        end
        chk("done_timeout", int'(done_seen), 1);
    endtask

    initial begin
        rst_            = 1'b1;
        start           = 1'b0;
        bus.issue_ready = 1'b0;
        #2 rst_ = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_stage", int'(stage), 0);
        chk("rst_addr_b", int'(bus.addr_b), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_ = 1'b1;

        // Full-rate FFT with a start pulse while busy, then an immediate rerun.
        rmode = 0;
        start_fft();
        while (cyc < start_cyc + 20) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        start_fft();
        wait_done();

        // Five-cycle stall on stage 0, j=3.
        rmode = 1;
        start_fft();
        wait_done();

        // Random backpressure.
        rmode = 2;
        for (int r = 0; r < 3; r++) begin
            start_fft();
            wait_done();
        end

        // Reset in the middle of stage 2.
        rmode = 0;
        start_fft();
        while (cyc < start_cyc + 25) begin
            @(posedge clk);
            #1;
        end
        chk("stage_before_reset", int'(stage), 2);
        #1 rst_ = 1'b0;
        #1;
        exp_issue.delete();
        exp_wb.delete();
        pending = 0;
        chk("abort_busy", busy, 0);
        chk("abort_issue_valid", bus.issue_valid, 0);
        chk("abort_wb_valid", bus.wb_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_stage", int'(stage), 0);
        @(posedge clk);
        #1 rst_ = 1'b1;
        repeat (15) @(posedge clk);

        start_fft();
        wait_done();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
